// File: rtl/dist_ram_pkg.sv
// Shared definitions for the distributed-RAM entry buffer controllers.
package dist_ram_pkg;

    localparam int DRD_SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/dist_ram_rd_skid.sv
// Two-entry FIFO skid buffer that catches RAM read data and holds the head
// entry stable for the downstream consumer.
module dist_ram_rd_skid
    import dist_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            count
);

    buf_state_t            state;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;

    // A push while TWO without a pop never happens: the issuer stops at depth.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_q <= push_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= push_data;
                    end else if (push) begin
                        tail_q <= push_data;
                        state  <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= push_data;
                        end else begin
                            state <= ONE;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign head_valid = (state != EMPTY);
    assign head_data  = head_q;
    assign count      = state;

endmodule

// File: rtl/dist_ram_rd_ctl.sv
// Read-side drain controller: walks the RAM read port in commit order, absorbs
// the registered read latency and streams entries out under valid/ready.
module dist_ram_rd_ctl
    import dist_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wr_commit,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  rd_release,
    output logic [ADDR_WIDTH:0]   entry_count,
    output logic                  overflow_err
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0]   pending;
    logic [ADDR_WIDTH:0]   level;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  inflight;
    logic                  overflow;
    logic [1:0]            buf_cnt;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  issue;
    logic                  full;
    logic                  commit_ok;

    assign pop       = out_valid && out_ready;
    assign full      = (level == FULL_LEVEL);
    assign commit_ok = wr_commit && !full;

    // Count the slot a read in flight will need, less the one freed this cycle.
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (pending != '0) && (occupancy < 3'(DRD_SKID_DEPTH));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            inflight <= 1'b0;
            pending  <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr + ADDR_WIDTH'(issue);
            inflight <= issue;

            case ({commit_ok, issue})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase

            case ({commit_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (wr_commit && full) begin
                overflow <= 1'b1;
            end
        end
    end

    dist_ram_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (inflight),
        .push_data  (rd_data),
        .pop        (pop),
        .head_valid (out_valid),
        .head_data  (out_data),
        .count      (buf_cnt)
    );

    assign rd_addr      = rd_ptr;
    assign rd_release   = pop;
    assign entry_count  = level;
    assign overflow_err = overflow;

endmodule
